mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch
// requester (I) and a data requester (D). Data wins ties, except that after
// MAX_DSTREAK consecutive data grants with a fetch waiting, the fetch is
// served. Every access is aborted with an error pulse if the memory does not
// acknowledge within TIMEOUT cycles of mem_req.
//
// Handshake: req_x is a level held by the requester until it sees ack_x or
// err_x; ack_x/err_x are one-cycle registered pulses. The memory side sees a
// registered command (mem_req plus fields) that stays constant until mem_ack
// is sampled high or the access times out. After every completion or timeout
// the arbiter spends one turnaround cycle in IDLE without granting. This gives
// the finished requester a cycle to drop or re-present its request before
// arbitration runs again, so a re-asserted data request competes fairly with
// a waiting fetch under the streak limit.
module mem_port_arbiter #(
  parameter int TIMEOUT     = 15,
  parameter int MAX_DSTREAK = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic [63:0] addr_i,
  input  logic        req_d,
  input  logic        we_d,
  input  logic [63:0] addr_d,
  input  logic [63:0] wdata_d,
  input  logic [3:0]  size_d,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [3:0]  mem_size,
  output logic        ack_i,
  output logic [31:0] rdata_i,
  output logic        err_i,
  output logic        ack_d,
  output logic [63:0] rdata_d,
  output logic        err_d,
  output logic        stall_if,
  output logic        stall_mem,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SW = (MAX_DSTREAK > 0) ? $clog2(MAX_DSTREAK + 1) : 1;

  state_t        state;
  state_t        state_next;
  logic [WW-1:0] wait_cnt;
  logic [SW-1:0] dstreak;
  logic          done;
  logic          streak_full;
  logic          grant_d;
  logic          grant_i;
  logic          timeout_hit;

  assign fsm_state = state;
  assign stall_if  = req_i & ~ack_i;
  assign stall_mem = req_d & ~ack_d;

  // Arbitration and next-state selection; no grant in a completion/abort cycle.
  always_comb begin
    done        = ack_i | ack_d | err_i | err_d;
    streak_full = (dstreak == SW'(MAX_DSTREAK));
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    timeout_hit = (wait_cnt == WW'(TIMEOUT - 1)) && !mem_ack;
    state_next  = state;
    case (state)
      IDLE: begin
        if (!done) begin
          if (req_d && !(req_i && streak_full)) begin
            grant_d    = 1'b1;
            state_next = BUSY_D;
          end else if (req_i) begin
            grant_i    = 1'b1;
            state_next = BUSY_I;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack || timeout_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Command latch, wait counter, streak counter and response registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= '0;
      ack_i     <= 1'b0;
      ack_d     <= 1'b0;
      err_i     <= 1'b0;
      err_d     <= 1'b0;
      rdata_i   <= '0;
      rdata_d   <= '0;
      wait_cnt  <= '0;
      dstreak   <= '0;
    end else begin
      ack_i <= 1'b0;
      ack_d <= 1'b0;
      err_i <= 1'b0;
      err_d <= 1'b0;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= we_d;
        mem_addr  <= addr_d;
        mem_wdata <= wdata_d;
        mem_size  <= size_d;
        wait_cnt  <= '0;
        if (req_i && !streak_full) dstreak <= dstreak + SW'(1);
      end else if (grant_i) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= addr_i;
        mem_wdata <= '0;
        mem_size  <= 4'b0100;
        wait_cnt  <= '0;
        dstreak   <= '0;
      end else if (state != IDLE) begin
        if (mem_ack) begin
          mem_req <= 1'b0;
          if (state == BUSY_I) begin
            ack_i   <= 1'b1;
            rdata_i <= mem_rdata[31:0];
          end else begin
            ack_d   <= 1'b1;
            rdata_d <= mem_rdata;
          end
        end else if (timeout_hit) begin
          mem_req <= 1'b0;
          if (state == BUSY_I) err_i <= 1'b1;
          else                 err_d <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + WW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change 1 time unit after
// the rising edge and outputs are checked at that same point, well away from
// the next edge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        req_i;
  logic [63:0] addr_i;
  logic        req_d;
  logic        we_d;
  logic [63:0] addr_d;
  logic [63:0] wdata_d;
  logic [3:0]  size_d;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [3:0]  mem_size;
  logic        ack_i;
  logic [31:0] rdata_i;
  logic        err_i;
  logic        ack_d;
  logic [63:0] rdata_d;
  logic        err_d;
  logic        stall_if;
  logic        stall_mem;
  logic [1:0]  fsm_state;

  int checks   = 0;
  int failures = 0;
  logic [63:0] last_rdata_d;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;

  mem_port_arbiter #(.TIMEOUT(15), .MAX_DSTREAK(3)) dut (
    .clk(clk), .reset(reset),
    .req_i(req_i), .addr_i(addr_i),
    .req_d(req_d), .we_d(we_d), .addr_d(addr_d), .wdata_d(wdata_d), .size_d(size_d),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size),
    .ack_i(ack_i), .rdata_i(rdata_i), .err_i(err_i),
    .ack_d(ack_d), .rdata_d(rdata_d), .err_d(err_d),
    .stall_if(stall_if), .stall_mem(stall_mem), .fsm_state(fsm_state)
  );

  // Clock and safety timeout.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_i = 1'b1; req_d = 1'b0; mem_ack = 1'b0;
    step(); step();
    checks++; if (fsm_state !== S_IDLE) begin failures++; $display("FAIL reset_state: got %0d required %0d", fsm_state, S_IDLE); end
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata, mem_size} !== '0) begin failures++; $display("FAIL reset_cmd: got req=%b addr=%h required all zero", mem_req, mem_addr); end
    checks++; if ({ack_i, err_i, ack_d, err_d, rdata_i, rdata_d} !== '0) begin failures++; $display("FAIL reset_resp: got ack_i=%b ack_d=%b rdata_i=%h rdata_d=%h required all zero", ack_i, ack_d, rdata_i, rdata_d); end
    checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL reset_stall_if: got %b required 1", stall_if); end
    req_i = 1'b0; req_d = 1'b1;
    #1;
    checks++; if ({stall_if, stall_mem} !== 2'b01) begin failures++; $display("FAIL reset_stall_follow: got %b required 01", {stall_if, stall_mem}); end
    req_d = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_fetch();
    req_i = 1'b1; addr_i = 64'h40;
    #1;
    checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL fetch_stall_c0: got %b required 1", stall_if); end
    step();
    checks++; if ({mem_req, mem_we, mem_size} !== {1'b1, 1'b0, 4'b0100}) begin failures++; $display("FAIL fetch_cmd: got req=%b we=%b size=%b required 1 0 0100", mem_req, mem_we, mem_size); end
    checks++; if (mem_addr !== 64'h40 || mem_wdata !== 64'h0) begin failures++; $display("FAIL fetch_addr: got addr=%h wdata=%h required 40 0", mem_addr, mem_wdata); end
    checks++; if (stall_if !== 1'b1 || ack_i !== 1'b0) begin failures++; $display("FAIL fetch_stall_c1: got stall=%b ack=%b required 1 0", stall_if, ack_i); end
    mem_ack = 1'b1; mem_rdata = 64'h00000000_8B1F03E0;
    step();
    mem_ack = 1'b0;
    checks++; if (ack_i !== 1'b1 || rdata_i !== 32'h8B1F03E0) begin failures++; $display("FAIL fetch_ack: got ack=%b rdata=%h required 1 8b1f03e0", ack_i, rdata_i); end
    checks++; if (mem_req !== 1'b0 || stall_if !== 1'b0 || fsm_state !== S_IDLE) begin failures++; $display("FAIL fetch_done: got req=%b stall=%b state=%0d required 0 0 0", mem_req, stall_if, fsm_state); end
    req_i = 1'b0;
    step();
    checks++; if (ack_i !== 1'b0 || rdata_i !== 32'h8B1F03E0) begin failures++; $display("FAIL fetch_pulse: got ack=%b rdata=%h required 0 8b1f03e0", ack_i, rdata_i); end
  endtask

  task automatic test_simultaneous();
    req_i = 1'b1; addr_i = 64'h80;
    req_d = 1'b1; we_d = 1'b0; addr_d = 64'h100; wdata_d = 64'h0; size_d = 4'b1000;
    step();
    checks++; if (fsm_state !== S_BUSY_D || mem_addr !== 64'h100) begin failures++; $display("FAIL simul_first: got state=%0d addr=%h required 2 100", fsm_state, mem_addr); end
    checks++; if ({stall_if, stall_mem} !== 2'b11) begin failures++; $display("FAIL simul_stalls: got %b required 11", {stall_if, stall_mem}); end
    mem_ack = 1'b1; mem_rdata = 64'h11223344_55667788;
    step();
    mem_ack = 1'b0;
    checks++; if (ack_d !== 1'b1 || rdata_d !== 64'h11223344_55667788) begin failures++; $display("FAIL simul_ack_d: got ack=%b rdata=%h required 1 1122334455667788", ack_d, rdata_d); end
    checks++; if (stall_mem !== 1'b0) begin failures++; $display("FAIL simul_stall_mem: got %b required 0", stall_mem); end
    req_d = 1'b0;
    step();
    checks++; if (mem_req !== 1'b0 || fsm_state !== S_IDLE) begin failures++; $display("FAIL simul_turnaround: got req=%b state=%0d required 0 0", mem_req, fsm_state); end
    step();
    checks++; if (fsm_state !== S_BUSY_I || mem_addr !== 64'h80 || mem_req !== 1'b1) begin failures++; $display("FAIL simul_fetch: got state=%0d addr=%h req=%b required 1 80 1", fsm_state, mem_addr, mem_req); end
    mem_ack = 1'b1; mem_rdata = 64'h0;
    step();
    mem_ack = 1'b0; req_i = 1'b0;
    checks++; if (ack_i !== 1'b1) begin failures++; $display("FAIL simul_ack_i: got %b required 1", ack_i); end
    step();
  endtask

  task automatic test_starvation();
    logic [1:0] exp_g [5];
    int d_left;
    exp_g = '{S_BUSY_D, S_BUSY_D, S_BUSY_D, S_BUSY_I, S_BUSY_D};
    d_left = 4;
    req_i = 1'b1; addr_i = 64'h200;
    req_d = 1'b1; we_d = 1'b0; size_d = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      addr_d = 64'h300 + 64'(k * 8);
      step();
      checks++; if (fsm_state !== exp_g[k]) begin failures++; $display("FAIL starve_grant%0d: got state=%0d required %0d", k, fsm_state, exp_g[k]); end
      mem_ack = 1'b1; mem_rdata = 64'hA0 + 64'(k);
      step();
      mem_ack = 1'b0;
      if (ack_d) begin
        last_rdata_d = 64'hA0 + 64'(k);
        req_d = 1'b0;
        d_left--;
      end
      if (ack_i) req_i = 1'b0;
      step();
      if (d_left > 0) req_d = 1'b1;
    end
    checks++; if (d_left !== 0 || req_i !== 1'b0) begin failures++; $display("FAIL starve_served: got d_left=%0d req_i=%b required 0 0", d_left, req_i); end
  endtask

  task automatic test_timeout();
    int hi;
    req_d = 1'b1; we_d = 1'b1; addr_d = 64'h500; wdata_d = 64'hDEAD; size_d = 4'b1000;
    mem_ack = 1'b0;
    step();
    hi = 0;
    checks++; if ({mem_we, mem_size} !== 5'b11000 || mem_wdata !== 64'hDEAD) begin failures++; $display("FAIL to_cmd: got we=%b size=%b wdata=%h required 1 1000 dead", mem_we, mem_size, mem_wdata); end
    if (mem_req) hi++;
    for (int i = 1; i < 15; i++) begin
      step();
      if (mem_req && !err_d && !ack_d && mem_addr == 64'h500) hi++;
    end
    step();
    checks++; if (hi !== 15) begin failures++; $display("FAIL to_req_cycles: got %0d required 15", hi); end
    checks++; if ({mem_req, err_d, ack_d} !== 3'b010 || fsm_state !== S_IDLE) begin failures++; $display("FAIL to_abort: got req=%b err=%b ack=%b state=%0d required 0 1 0 0", mem_req, err_d, ack_d, fsm_state); end
    checks++; if (rdata_d !== last_rdata_d) begin failures++; $display("FAIL to_rdata_hold: got %h required %h", rdata_d, last_rdata_d); end
    req_d = 1'b0; we_d = 1'b0;
    step();
    checks++; if (err_d !== 1'b0 || ack_d !== 1'b0) begin failures++; $display("FAIL to_pulse: got err=%b ack=%b required 0 0", err_d, ack_d); end
  endtask

  task automatic test_ack_at_timeout();
    req_i = 1'b1; addr_i = 64'h540;
    step();
    for (int i = 1; i < 15; i++) step();
    mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF_1234_5678;
    step();
    mem_ack = 1'b0; req_i = 1'b0;
    checks++; if ({ack_i, err_i} !== 2'b10 || rdata_i !== 32'h12345678) begin failures++; $display("FAIL edge_ack: got ack=%b err=%b rdata=%h required 1 0 12345678", ack_i, err_i, rdata_i); end
    step();
  endtask

  task automatic test_reset_mid();
    req_i = 1'b1; addr_i = 64'h600;
    step();
    checks++; if (fsm_state !== S_BUSY_I) begin failures++; $display("FAIL rst_mid_busy: got %0d required 1", fsm_state); end
    reset = 1'b0;
    step();
    checks++; if (mem_req !== 1'b0 || fsm_state !== S_IDLE) begin failures++; $display("FAIL rst_mid_drop: got req=%b state=%0d required 0 0", mem_req, fsm_state); end
    reset = 1'b1; req_i = 1'b0;
    step();
    mem_ack = 1'b1; mem_rdata = 64'h5555_5555_5555_5555;
    step();
    mem_ack = 1'b0;
    checks++; if ({ack_i, err_i, ack_d, err_d, mem_req} !== 5'b0 || fsm_state !== S_IDLE) begin failures++; $display("FAIL rst_mid_noack: got ack_i=%b err_i=%b req=%b state=%0d required 0 0 0 0", ack_i, err_i, mem_req, fsm_state); end
    checks++; if (rdata_i !== 32'h0 || rdata_d !== 64'h0 || mem_addr !== 64'h0) begin failures++; $display("FAIL rst_mid_zero: got rdata_i=%h rdata_d=%h addr=%h required 0 0 0", rdata_i, rdata_d, mem_addr); end
  endtask

  task automatic test_back_to_back();
    int grants;
    grants = 0;
    req_d = 1'b1; we_d = 1'b0; addr_d = 64'h700; size_d = 4'b0001;
    step();
    if (mem_req) grants++;
    checks++; if (mem_addr !== 64'h700 || mem_size !== 4'b0001) begin failures++; $display("FAIL b2b_cmd1: got addr=%h size=%b required 700 0001", mem_addr, mem_size); end
    mem_ack = 1'b1; mem_rdata = 64'h0101;
    step();
    mem_ack = 1'b0; addr_d = 64'h708;
    checks++; if (ack_d !== 1'b1 || rdata_d !== 64'h0101) begin failures++; $display("FAIL b2b_ack1: got ack=%b rdata=%h required 1 0101", ack_d, rdata_d); end
    step();
    checks++; if (mem_req !== 1'b0 || ack_d !== 1'b0) begin failures++; $display("FAIL b2b_gap: got req=%b ack=%b required 0 0", mem_req, ack_d); end
    step();
    if (mem_req) grants++;
    checks++; if (mem_addr !== 64'h708 || fsm_state !== S_BUSY_D) begin failures++; $display("FAIL b2b_cmd2: got addr=%h state=%0d required 708 2", mem_addr, fsm_state); end
    mem_ack = 1'b1; mem_rdata = 64'h0202;
    step();
    mem_ack = 1'b0; req_d = 1'b0;
    checks++; if (ack_d !== 1'b1 || rdata_d !== 64'h0202) begin failures++; $display("FAIL b2b_ack2: got ack=%b rdata=%h required 1 0202", ack_d, rdata_d); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (mem_req) grants++;
    end
    checks++; if (grants !== 2) begin failures++; $display("FAIL b2b_grants: got %0d required 2", grants); end
  endtask

  initial begin
    reset = 1'b0; req_i = 1'b0; addr_i = '0; req_d = 1'b0; we_d = 1'b0;
    addr_d = '0; wdata_d = '0; size_d = '0; mem_ack = 1'b0; mem_rdata = '0;
    last_rdata_d = '0;
    #1;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
